// File: rtl/blocpu_pkg.sv
// Shared constants and types for the blocpu loader: command bytes, error codes
// and the frame parser state encoding.
package blocpu_pkg;
  localparam int CPU_WIDTH         = 8;
  localparam int INSTRUCTION_WIDTH = 12;
  localparam int ADDR_WIDTH        = 16;

  localparam logic [CPU_WIDTH-1:0] CMD_I  = 8'h49;
  localparam logic [CPU_WIDTH-1:0] CMD_D  = 8'h44;
  localparam logic [CPU_WIDTH-1:0] CMD_G  = 8'h47;
  localparam logic [CPU_WIDTH-1:0] CMD_R  = 8'h52;
  localparam logic [CPU_WIDTH-1:0] CHK_OK = 8'h00;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_CMD  = 2'd1,
    ERR_BUSY     = 2'd2,
    ERR_CHECKSUM = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_COUNT, ST_DATA_HI, ST_DATA_LO, ST_CHECK, ST_GAP
  } state_e;

  function automatic logic is_cmd(input logic [CPU_WIDTH-1:0] b);
    return (b == CMD_I) || (b == CMD_D) || (b == CMD_G) || (b == CMD_R);
  endfunction
endpackage

// File: rtl/blocpu_loader_frame_chk.sv
// Running 8-bit frame sum; sum_ok tells whether the byte on data would close
// the frame with a zero total.
module blocpu_loader_frame_chk
  import blocpu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 accept,
  input  logic [CPU_WIDTH-1:0] data,
  output logic                 sum_ok
);
  logic [CPU_WIDTH-1:0] sum;
  logic [CPU_WIDTH-1:0] total;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (accept) begin
      sum <= start ? data : sum + data;
    end
  end

  assign total  = sum + data;
  assign sum_ok = (total == CHK_OK);
endmodule

// File: rtl/blocpu_loader.sv
// Framed byte-stream loader for blocpu_core: writes instruction/data memory,
// then starts, stops and watches the core for halt.
module blocpu_loader
  import blocpu_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CPU_WIDTH-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         imem_we,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] imem_wdata,
  output logic                         dmem_we,
  output logic [ADDR_WIDTH-1:0]        dmem_addr,
  output logic [CPU_WIDTH-1:0]         dmem_wdata,
  input  logic                         core_halted,
  output logic                         core_run,
  output logic                         core_reset_req,
  output logic [ADDR_WIDTH-1:0]        core_start_ip,
  output logic                         frame_done,
  output logic                         frame_error,
  output logic [1:0]                   error_code
);
  // Handshake: a byte transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready depends only on state and reset, never on in_valid.
  state_e                state;
  logic [CPU_WIDTH-1:0]  cmd;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0]            remaining;
  logic [3:0]            hi_nib;
  logic                  accept;
  logic                  sum_ok;

  assign in_ready = !reset && (state != ST_GAP);
  assign accept   = in_valid && in_ready;

  blocpu_loader_frame_chk u_frame_chk (
    .clock  (clock),
    .reset  (reset),
    .start  (state == ST_CMD),
    .accept (accept),
    .data   (in_data),
    .sum_ok (sum_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_CMD;
      cmd            <= '0;
      busy           <= 1'b0;
      addr           <= '0;
      remaining      <= '0;
      hi_nib         <= '0;
      imem_we        <= 1'b0;
      imem_addr      <= '0;
      imem_wdata     <= '0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      core_run       <= 1'b0;
      core_reset_req <= 1'b0;
      core_start_ip  <= '0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
      error_code     <= ERR_NONE;
    end else begin
      imem_we        <= 1'b0;
      dmem_we        <= 1'b0;
      core_reset_req <= 1'b0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;

      // Halt drops run; a G completing in the same cycle overrides below.
      if (core_halted && core_run) core_run <= 1'b0;

      if (state == ST_GAP) begin
        state <= ST_CMD;
      end else if (accept) begin
        case (state)
          ST_CMD: begin
            if (is_cmd(in_data)) begin
              cmd   <= in_data;
              busy  <= core_run && (in_data != CMD_R);
              state <= (in_data == CMD_R) ? ST_CHECK : ST_ADDR_H;
            end else begin
              frame_error <= 1'b1;
              error_code  <= ERR_BAD_CMD;
            end
          end
          ST_ADDR_H: begin
            addr[15:8] <= in_data;
            state      <= ST_ADDR_L;
          end
          ST_ADDR_L: begin
            addr[7:0] <= in_data;
            state     <= (cmd == CMD_G) ? ST_CHECK : ST_COUNT;
          end
          ST_COUNT: begin
            // A count byte of zero means 256 words.
            remaining <= {(in_data == 8'd0), in_data};
            state     <= (cmd == CMD_I) ? ST_DATA_HI : ST_DATA_LO;
          end
          ST_DATA_HI: begin
            hi_nib <= in_data[3:0];
            state  <= ST_DATA_LO;
          end
          ST_DATA_LO: begin
            if (!busy) begin
              if (cmd == CMD_I) begin
                imem_we    <= 1'b1;
                imem_addr  <= addr;
                imem_wdata <= {hi_nib, in_data};
              end else begin
                dmem_we    <= 1'b1;
                dmem_addr  <= addr;
                dmem_wdata <= in_data;
              end
            end
            addr      <= addr + 16'd1;
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) state <= ST_CHECK;
            else                   state <= (cmd == CMD_I) ? ST_DATA_HI : ST_DATA_LO;
          end
          ST_CHECK: begin
            state <= ST_GAP;
            if (busy) begin
              frame_error <= 1'b1;
              error_code  <= ERR_BUSY;
            end else if (!sum_ok) begin
              frame_error <= 1'b1;
              error_code  <= ERR_CHECKSUM;
            end else begin
              frame_done <= 1'b1;
              error_code <= ERR_NONE;
              if (cmd == CMD_G) begin
                core_start_ip  <= addr;
                core_run       <= 1'b1;
                core_reset_req <= 1'b1;
              end else if (cmd == CMD_R) begin
                core_run       <= 1'b0;
                core_reset_req <= 1'b1;
              end
            end
          end
          default: state <= ST_CMD;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_blocpu_loader.sv
// Directed bench for blocpu_loader: framed byte stimulus, write scoreboard and
// per-frame status checks.
module tb_blocpu_loader;
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [11:0] imem_wdata;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        core_halted;
  logic        core_run;
  logic        core_reset_req;
  logic [15:0] core_start_ip;
  logic        frame_done;
  logic        frame_error;
  logic [1:0]  error_code;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] imem_q[$];
  logic [31:0] dmem_q[$];
  logic [7:0]  frame_q[$];

  blocpu_loader dut (
    .clock          (clock),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .core_halted    (core_halted),
    .core_run       (core_run),
    .core_reset_req (core_reset_req),
    .core_start_ip  (core_start_ip),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .error_code     (error_code)
  );

  // clock / reset
  always #5 clock = ~clock;

  // write monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (imem_we) imem_q.push_back({imem_addr, 4'h0, imem_wdata});
    if (dmem_we) dmem_q.push_back({dmem_addr, 8'h00, dmem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit add_chk);
    logic [7:0] s = 8'h00;
    if (add_chk) begin
      foreach (frame_q[i]) s = s + frame_q[i];
      frame_q.push_back(8'h00 - s);
    end
    foreach (frame_q[i]) send_byte(frame_q[i]);
    frame_q.delete();
  endtask

  // checks the GAP cycle that follows every CHECK byte
  task automatic gap_check(input string tag, input logic done, input logic err,
                           input logic [1:0] code);
    @(negedge clock);
    check({tag, "_done"},     {31'd0, frame_done},  {31'd0, done});
    check({tag, "_error"},    {31'd0, frame_error}, {31'd0, err});
    check({tag, "_code"},     {30'd0, error_code},  {30'd0, code});
    check({tag, "_gap_rdy"},  {31'd0, in_ready},    32'd0);
  endtask

  // scoreboard: drain expected queue against captured writes
  task automatic compare_writes(input string tag, input bit use_imem);
    logic [31:0] g[$];
    logic [31:0] e;
    logic [31:0] v;
    g = use_imem ? imem_q : dmem_q;
    if (use_imem) imem_q.delete();
    else          dmem_q.delete();
    check({tag, "_count"}, g.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      v = (g.size() > 0) ? g.pop_front() : 32'hDEAD_BEEF;
      check({tag, "_write"}, v, e);
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    core_halted = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_core_run", {31'd0, core_run}, 32'd0);
    check("rst_imem_we",  {31'd0, imem_we},  32'd0);
    check("rst_code",     {30'd0, error_code}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_rdy", {31'd0, in_ready}, 32'd1);

    // I frame, two words
    frame_q = '{8'h49, 8'h00, 8'h10, 8'h02, 8'h08, 8'h01, 8'h03, 8'hC7, 8'hD2};
    send_frame(1'b0);
    gap_check("i_good", 1'b1, 1'b0, 2'd0);
    @(negedge clock);
    check("i_good_rdy_back", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({16'h0010, 4'h0, 12'h801});
    exp_q.push_back({16'h0011, 4'h0, 12'h3C7});
    compare_writes("i_good", 1'b1);

    // G frame, then halt
    frame_q = '{8'h47, 8'h00, 8'h10, 8'hA9};
    send_frame(1'b0);
    gap_check("g1", 1'b1, 1'b0, 2'd0);
    check("g1_reset_req", {31'd0, core_reset_req}, 32'd1);
    check("g1_run",       {31'd0, core_run},       32'd1);
    check("g1_ip",        {16'd0, core_start_ip},  32'h0010);
    core_halted = 1'b1;
    @(negedge clock);
    core_halted = 1'b0;
    check("halt_run",   {31'd0, core_run},    32'd0);
    check("halt_done",  {31'd0, frame_done},  32'd0);
    check("halt_error", {31'd0, frame_error}, 32'd0);

    // D frame with address wrap
    frame_q = '{8'h44, 8'hFF, 8'hFF, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_frame(1'b1);
    gap_check("d_wrap", 1'b1, 1'b0, 2'd0);
    exp_q.push_back({16'hFFFF, 8'h00, 8'hAA});
    exp_q.push_back({16'h0000, 8'h00, 8'hBB});
    exp_q.push_back({16'h0001, 8'h00, 8'hCC});
    compare_writes("d_wrap", 1'b0);

    // D frame, count byte 0 = 256 bytes
    frame_q = '{8'h44, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) begin
      frame_q.push_back(8'(i ^ 8'h5A));
      exp_q.push_back({16'h0100 + 16'(i), 8'h00, 8'(i ^ 8'h5A)});
    end
    send_frame(1'b1);
    gap_check("d_256", 1'b1, 1'b0, 2'd0);
    compare_writes("d_256", 1'b0);

    // I frame with bad checksum still writes
    frame_q = '{8'h49, 8'h00, 8'h10, 8'h02, 8'h08, 8'h01, 8'h03, 8'hC7, 8'hD3};
    send_frame(1'b0);
    gap_check("i_badchk", 1'b0, 1'b1, 2'd3);
    check("i_badchk_run", {31'd0, core_run}, 32'd0);
    exp_q.push_back({16'h0010, 4'h0, 12'h801});
    exp_q.push_back({16'h0011, 4'h0, 12'h3C7});
    compare_writes("i_badchk", 1'b1);

    // busy: D while running, then R
    frame_q = '{8'h47, 8'h00, 8'h10, 8'hA9};
    send_frame(1'b0);
    gap_check("g2", 1'b1, 1'b0, 2'd0);
    check("g2_run", {31'd0, core_run}, 32'd1);
    frame_q = '{8'h44, 8'h00, 8'h40, 8'h02, 8'h11, 8'h22};
    send_frame(1'b1);
    gap_check("d_busy", 1'b0, 1'b1, 2'd2);
    check("d_busy_run", {31'd0, core_run}, 32'd1);
    compare_writes("d_busy", 1'b0);
    frame_q = '{8'h52, 8'hAE};
    send_frame(1'b0);
    gap_check("r", 1'b1, 1'b0, 2'd0);
    check("r_run",       {31'd0, core_run},       32'd0);
    check("r_reset_req", {31'd0, core_reset_req}, 32'd1);
    check("r_ip",        {16'd0, core_start_ip},  32'h0010);

    // reset mid-frame, unknown command, then a good G
    send_byte(8'h49);
    send_byte(8'h00);
    send_byte(8'h10);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_rdy",  {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    send_byte(8'h00);
    @(negedge clock);
    check("badcmd_error", {31'd0, frame_error}, 32'd1);
    check("badcmd_code",  {30'd0, error_code},  32'd1);
    check("badcmd_rdy",   {31'd0, in_ready},    32'd1);
    frame_q = '{8'h47, 8'h00, 8'h20};
    send_frame(1'b1);
    gap_check("g3", 1'b1, 1'b0, 2'd0);
    check("g3_run", {31'd0, core_run},      32'd1);
    check("g3_ip",  {16'd0, core_start_ip}, 32'h0020);
    compare_writes("midrst_imem", 1'b1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
